// File: rtl/ard_link_pkg.sv
// ard_link_pkg: shared definitions for the Arduino command link.
//   - one-hot command codes driven on sig_out[4:1]
//   - sig_out bit-field indices (strobe on bit 0)
//   - command-sequence and per-command phase state encodings
//   - pack_sig(): builds a sig_out word from a code and a strobe bit
package ard_link_pkg;

    localparam int unsigned CMD_W       = 4;
    localparam int unsigned SIG_W       = CMD_W + 1;
    localparam int unsigned SIG_STB     = 0;
    localparam int unsigned SIG_CMD_LSB = 1;
    localparam int unsigned SIG_CMD_MSB = SIG_W - 1;

    localparam logic [CMD_W-1:0] CMD_SEARCH    = 4'b1000;
    localparam logic [CMD_W-1:0] CMD_PLACE     = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_RESET_POS = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_STOP      = 4'b0001;

    typedef enum logic [2:0] {
        SQ_RESET_POS,
        SQ_SEARCH,
        SQ_WAIT_OBJ,
        SQ_PLACE,
        SQ_STOP,
        SQ_DONE,
        SQ_FAULT
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_SETUP,
        PH_STROBE,
        PH_RELEASE
    } phase_e;

    // Place a command code and strobe bit into their sig_out fields.
    function automatic logic [SIG_W-1:0] pack_sig(input logic [CMD_W-1:0] cmd, input logic stb);
        logic [SIG_W-1:0] s;
        s = '0;
        s[SIG_CMD_MSB:SIG_CMD_LSB] = cmd;
        s[SIG_STB] = stb;
        return s;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// hold_timer: saturating up-counter measuring cycles since the current
// command code was loaded, with threshold compares for the link FSM.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   clear          - synchronous load of zero (takes priority over count_en)
//   count_en       - advance the count by one, saturating at all-ones
//   ge_setup_c     - count >= SETUP_AT   (combinational)
//   ge_hold_c      - count >= HOLD_AT    (combinational)
//   ge_timeout_c   - count >= TIMEOUT_AT (combinational)
module hold_timer #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned SETUP_AT   = 1,
    parameter int unsigned HOLD_AT    = 2,
    parameter int unsigned TIMEOUT_AT = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic ge_setup_c,
    output logic ge_hold_c,
    output logic ge_timeout_c
);

    logic [CNT_W-1:0] cnt;

    // Count up, stick at the maximum instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (count_en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign ge_setup_c   = (cnt >= CNT_W'(SETUP_AT));
    assign ge_hold_c    = (cnt >= CNT_W'(HOLD_AT));
    assign ge_timeout_c = (cnt >= CNT_W'(TIMEOUT_AT));

endmodule

// File: rtl/arduino_cmd_link.sv
// arduino_cmd_link: sequences the arm routine RESET_POSITION -> SEARCH ->
// (object found) -> PLACE -> STOP on the Arduino GPIO header, each command
// presented as a one-hot code with setup/hold-timed strobe.
// Optional feature macro: ARD_ACK_EN enables the 4-phase Arduino acknowledge
// with timeout, retry and FAULT; without it completion is time-only.
// Ports:
//   clock, reset   - 50 MHz clock, synchronous active-high reset
//   object_found   - vision detect flag (level or pulse)
//   ard_ack        - Arduino acknowledge, asynchronous to clock
//   sig_out[4:0]   - [4:1] one-hot command, [0] strobe
//   busy           - command handshake in progress
//   done           - routine finished
//   error          - fault latched
//   retry_cnt[1:0] - re-issues of the current command
import ard_link_pkg::*;

module arduino_cmd_link #(
    parameter int unsigned SETUP_CYCLES = 25_000_000,
    parameter int unsigned HOLD_CYCLES  = 50_000_000,
    parameter int unsigned ACK_TIMEOUT  = 100_000_000,
    parameter int unsigned MAX_RETRY    = 2,
    parameter int unsigned CNT_W        =
        $clog2(((HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT) + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             object_found,
    input  logic             ard_ack,
    output logic [SIG_W-1:0] sig_out,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       retry_cnt
);

    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

    seq_state_e seq;
    phase_e     phase;
    logic       obj_seen;

    logic hs_active_c;
    logic strobe_done_c;
    logic release_done_c;
    logic retry_c;
    logic tmr_clear_c;
    logic ge_setup_c;
    logic ge_hold_c;
    logic ge_timeout_c;

    // Timer runs from the code change; the ack timeout is counted from
    // strobe rise, which is always SETUP_CYCLES after the code change.
    hold_timer #(
        .CNT_W      (CNT_W),
        .SETUP_AT   (SETUP_CYCLES),
        .HOLD_AT    (HOLD_CYCLES),
        .TIMEOUT_AT (SETUP_CYCLES + ACK_TIMEOUT)
    ) u_timer (
        .clock        (clock),
        .reset        (reset),
        .clear        (tmr_clear_c),
        .count_en     (hs_active_c),
        .ge_setup_c   (ge_setup_c),
        .ge_hold_c    (ge_hold_c),
        .ge_timeout_c (ge_timeout_c)
    );

`ifdef ARD_ACK_EN
    logic ack_meta;
    logic ack_s;

    // Two-flop synchroniser for the asynchronous acknowledge.
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= ard_ack;
            ack_s    <= ack_meta;
        end
    end
`else
    logic unused_sigs;
    assign unused_sigs = ^{ard_ack, ge_timeout_c, retry_c, RETRY_LIMIT};
`endif

    // Phase completion decode; ack, when enabled, wins over a same-cycle timeout.
    always_comb begin
        hs_active_c    = (seq == SQ_RESET_POS) || (seq == SQ_SEARCH) ||
                         (seq == SQ_PLACE)     || (seq == SQ_STOP);
        strobe_done_c  = 1'b0;
        release_done_c = 1'b0;
        retry_c        = 1'b0;
        if (hs_active_c) begin
            case (phase)
                PH_STROBE: begin
`ifdef ARD_ACK_EN
                    strobe_done_c = ge_hold_c && ack_s;
                    retry_c       = ge_timeout_c && !ack_s;
`else
                    strobe_done_c = ge_hold_c;
`endif
                end
                PH_RELEASE: begin
`ifdef ARD_ACK_EN
                    release_done_c = !ack_s;
`else
                    release_done_c = 1'b1;
`endif
                end
                default: ;
            endcase
        end
        tmr_clear_c = release_done_c || retry_c || (seq == SQ_WAIT_OBJ);
    end

    // Sequence and phase FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            seq       <= SQ_RESET_POS;
            phase     <= PH_ISSUE;
            obj_seen  <= 1'b0;
            sig_out   <= pack_sig(CMD_RESET_POS, 1'b0);
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            retry_cnt <= 2'd0;
        end else begin
            // Detections during the SEARCH handshake are remembered for WAIT_OBJ.
            if ((seq == SQ_SEARCH) && object_found) begin
                obj_seen <= 1'b1;
            end
            case (seq)
                SQ_WAIT_OBJ: begin
                    if (object_found || obj_seen) begin
                        seq      <= SQ_PLACE;
                        phase    <= PH_ISSUE;
                        sig_out  <= pack_sig(CMD_PLACE, 1'b0);
                        busy     <= 1'b1;
                        obj_seen <= 1'b0;
                    end
                end
                SQ_DONE, SQ_FAULT: ;
                default: begin
                    case (phase)
                        PH_ISSUE: phase <= PH_SETUP;
                        PH_SETUP: begin
                            if (ge_setup_c) begin
                                phase            <= PH_STROBE;
                                sig_out[SIG_STB] <= 1'b1;
                            end
                        end
                        PH_STROBE: begin
                            if (strobe_done_c) begin
                                phase            <= PH_RELEASE;
                                sig_out[SIG_STB] <= 1'b0;
                            end
`ifdef ARD_ACK_EN
                            else if (retry_c) begin
                                phase            <= PH_ISSUE;
                                sig_out[SIG_STB] <= 1'b0;
                                if (retry_cnt == RETRY_LIMIT) begin
                                    seq     <= SQ_FAULT;
                                    sig_out <= pack_sig(CMD_STOP, 1'b0);
                                    error   <= 1'b1;
                                    busy    <= 1'b0;
                                end else begin
                                    retry_cnt <= retry_cnt + 2'd1;
                                end
                            end
`endif
                        end
                        PH_RELEASE: begin
                            if (release_done_c) begin
                                phase     <= PH_ISSUE;
                                retry_cnt <= 2'd0;
                                case (seq)
                                    SQ_RESET_POS: begin
                                        seq     <= SQ_SEARCH;
                                        sig_out <= pack_sig(CMD_SEARCH, 1'b0);
                                    end
                                    SQ_SEARCH: begin
                                        seq  <= SQ_WAIT_OBJ;
                                        busy <= 1'b0;
                                    end
                                    SQ_PLACE: begin
                                        seq     <= SQ_STOP;
                                        sig_out <= pack_sig(CMD_STOP, 1'b0);
                                    end
                                    SQ_STOP: begin
                                        seq  <= SQ_DONE;
                                        done <= 1'b1;
                                        busy <= 1'b0;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arduino_cmd_link.sv
// tb_arduino_cmd_link: directed self-checking bench for arduino_cmd_link
// with SETUP=4, HOLD=10, TIMEOUT=20, MAX_RETRY=2. Edge numbers in the
// comments count rising edges after reset is released. Builds with and
// without ARD_ACK_EN select the matching directed sequence.
module tb_arduino_cmd_link;

    logic       clock = 1'b0;
    logic       reset;
    logic       object_found;
    logic       ard_ack;
    logic [4:0] sig_out;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    arduino_cmd_link #(
        .SETUP_CYCLES (4),
        .HOLD_CYCLES  (10),
        .ACK_TIMEOUT  (20),
        .MAX_RETRY    (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .object_found (object_found),
        .ard_ack      (ard_ack),
        .sig_out      (sig_out),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .retry_cnt    (retry_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_sig(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        object_found = 1'b0;
        ard_ack      = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_sig({tag, "_sig"}, sig_out, 5'b00100);
        check_bit({tag, "_busy"}, busy, 1'b1);
        check_bit({tag, "_done"}, done, 1'b0);
        check_bit({tag, "_error"}, error, 1'b0);
        check_int({tag, "_retry"}, int'(retry_cnt), 0);
    endtask

    initial begin
`ifndef ARD_ACK_EN
        // Full routine with an object seen during the SEARCH handshake.
        do_reset();
        check_reset_state("rst");
        tick(4);                                        // e4
        check_sig("setup_low", sig_out, 5'b00100);
        tick(1);                                        // e5
        check_sig("strobe_rise", sig_out, 5'b00101);
        tick(5);                                        // e10
        check_sig("strobe_held", sig_out, 5'b00101);
        tick(1);                                        // e11
        check_sig("strobe_fall", sig_out, 5'b00100);
        tick(1);                                        // e12
        check_sig("search_code", sig_out, 5'b10000);
        tick(2);                                        // e14
        object_found = 1'b1;
        tick(1);                                        // e15 pulse sampled
        object_found = 1'b0;
        tick(2);                                        // e17
        check_sig("search_strobe", sig_out, 5'b10001);
        tick(7);                                        // e24
        check_sig("wait_obj_code", sig_out, 5'b10000);
        check_bit("wait_obj_busy", busy, 1'b0);
        tick(1);                                        // e25
        check_sig("place_no_stall", sig_out, 5'b01000);
        check_bit("place_busy", busy, 1'b1);
        tick(10);                                       // e35
        check_sig("place_strobe", sig_out, 5'b01001);
        tick(2);                                        // e37
        check_sig("stop_code", sig_out, 5'b00010);
        tick(11);                                       // e48
        check_sig("stop_released", sig_out, 5'b00010);
        check_bit("done_early", done, 1'b0);
        tick(1);                                        // e49
        check_bit("done_set", done, 1'b1);
        check_bit("done_busy", busy, 1'b0);
        check_sig("done_sig", sig_out, 5'b00010);
        tick(10);                                       // e59
        check_bit("done_holds", done, 1'b1);

        // Pulse outside SEARCH is ignored; WAIT_OBJ waits for a live detect.
        do_reset();
        tick(2);                                        // e2
        object_found = 1'b1;
        tick(1);                                        // e3
        object_found = 1'b0;
        tick(22);                                       // e25
        check_sig("ignored_pulse_sig", sig_out, 5'b10000);
        check_bit("ignored_pulse_busy", busy, 1'b0);
        tick(4);                                        // e29
        object_found = 1'b1;
        tick(1);                                        // e30
        object_found = 1'b0;
        check_sig("live_detect_place", sig_out, 5'b01000);
        tick(7);                                        // e37, PLACE strobing
        check_sig("place_mid_strobe", sig_out, 5'b01001);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_sig("midrst_sig", sig_out, 5'b00100);
        check_bit("midrst_busy", busy, 1'b1);
        check_bit("midrst_done", done, 1'b0);
        tick(4);
        check_sig("restart_setup", sig_out, 5'b00100);
        tick(1);
        check_sig("restart_strobe", sig_out, 5'b00101);
`else
        // Ack 3 cycles after strobe, released 2 cycles later.
        do_reset();
        check_reset_state("rst");
        tick(5);                                        // e5
        check_sig("ack_strobe_rise", sig_out, 5'b00101);
        tick(3);                                        // e8
        ard_ack = 1'b1;
        tick(2);                                        // e10
        ard_ack = 1'b0;
        check_sig("ack_strobe_held", sig_out, 5'b00101);
        tick(1);                                        // e11
        check_sig("ack_fall_at_hold", sig_out, 5'b00100);
        tick(1);                                        // e12
        check_sig("ack_wait_low", sig_out, 5'b00100);
        tick(1);                                        // e13
        check_sig("ack_next_issue", sig_out, 5'b10000);
        check_int("ack_retry0", int'(retry_cnt), 0);

        // Late ack stretches the SEARCH strobe past HOLD.
        tick(12);                                       // e25
        check_sig("late_ack_strobe", sig_out, 5'b10001);
        ard_ack = 1'b1;
        tick(2);                                        // e27
        check_sig("late_ack_pending", sig_out, 5'b10001);
        tick(1);                                        // e28
        check_sig("late_ack_fall", sig_out, 5'b10000);
        ard_ack = 1'b0;
        tick(2);                                        // e30
        check_bit("late_release_busy", busy, 1'b1);
        tick(1);                                        // e31
        check_bit("late_wait_obj_busy", busy, 1'b0);
        check_int("late_retry0", int'(retry_cnt), 0);

        // No ack at all: three strobes, two retries, then FAULT.
        do_reset();
        begin
            int   rises;
            logic prev;
            rises = 0;
            prev  = 1'b0;
            for (int i = 1; i <= 75; i++) begin
                tick(1);
                if (sig_out[0] && !prev) rises++;
                prev = sig_out[0];
                if (i == 24) check_int("to_retry_before", int'(retry_cnt), 0);
                if (i == 25) check_int("to_retry1", int'(retry_cnt), 1);
                if (i == 25) check_sig("to_strobe_drop", sig_out, 5'b00100);
                if (i == 50) check_int("to_retry2", int'(retry_cnt), 2);
                if (i == 74) check_bit("to_no_error_yet", error, 1'b0);
            end
            check_int("to_strobe_pulses", rises, 3);
        end
        check_bit("fault_error", error, 1'b1);
        check_sig("fault_sig", sig_out, 5'b00010);
        check_bit("fault_busy", busy, 1'b0);
        tick(5);
        check_bit("fault_holds", error, 1'b1);

        // Synchronised ack rises on the same edge the timeout is reached.
        do_reset();
        tick(22);                                       // e22
        ard_ack = 1'b1;
        tick(2);                                        // e24
        check_sig("tie_strobe", sig_out, 5'b00101);
        tick(1);                                        // e25
        check_sig("tie_release", sig_out, 5'b00100);
        check_int("tie_retry0", int'(retry_cnt), 0);
        check_bit("tie_no_error", error, 1'b0);
        ard_ack = 1'b0;
        tick(3);                                        // e28
        check_sig("tie_next_cmd", sig_out, 5'b10000);
        check_int("tie_retry_final", int'(retry_cnt), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
